carry_select_pipe_adder: RTL and testbench
==========================================

CARRY_SELECT_PIPE_ADDER -- requirements
Module: carry_select_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter SEG, default 4, carry-select segment width; WIDTH SHALL be an integer multiple of SEG, else elaboration SHALL fail.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 a_in, b_in  input  WIDTH each  operands.
REQ-008 cin_in  input  1  carry in, add mode only.
REQ-009 sub_in  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 s_out  output  WIDTH  sum/difference.
REQ-013 cout_out  output  1  carry out of MSB; in subtract mode 1 = no borrow.
REQ-014 ovf_out  output  1  signed overflow; present only with CSA_OVF_EN (REQ-031).

Function
REQ-015 Segment count NSEG = WIDTH/SEG; segment 0 SHALL use a single SEG-bit adder fed by the effective carry in.
REQ-016 Segments 1..NSEG-1 SHALL each compute two SEG-bit results with carry in 0 and 1 respectively; the carry from segment k-1 SHALL select result and carry of segment k.
REQ-017 Add: result = a + b + cin_in. Subtract: result = a + ~b + 1; cin_in ignored.
REQ-018 {cout_out, s_out} SHALL equal the exact (WIDTH+1)-bit result of REQ-017; no truncation other than the carry position.
REQ-019 Pipeline, 2 register stages: stage 1 holds a, b after subtract inversion, effective carry in, sub, and all segment dual results; stage 2 holds selected sum, cout, ovf.
REQ-020 An input is accepted when in_valid && in_ready; its result SHALL appear with out_valid=1 exactly 2 cycles later when out_ready is held high.
REQ-021 Global advance: adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally. in_ready SHALL NOT depend on in_valid.
REQ-022 When adv=0 both stages and their valid bits SHALL hold; s_out, cout_out, ovf_out SHALL remain stable while out_valid && !out_ready.
REQ-023 When adv=1 each stage valid bit SHALL load the previous stage valid bit (stage 1 loads in_valid); bubbles are not collapsed.
REQ-024 Sustained throughput SHALL be one result per cycle with out_ready=1; results SHALL leave in acceptance order with no loss or duplication.
REQ-025 Data registers of a stage whose incoming valid is 0 MAY load don't-care values; outputs SHALL only be checked when out_valid=1.

Reset
REQ-026 With rst_n=0 at a rising edge, both stage valid bits, out_valid, s_out, cout_out and ovf_out SHALL become 0.
REQ-027 During reset in_ready SHALL read 1 (out_valid=0); inputs presented while rst_n=0 SHALL be discarded.
REQ-028 Reset mid-operation SHALL drop all in-flight results; the first result after release SHALL come from the first input accepted after release.
REQ-029 The first input may be accepted on the first edge where rst_n=1.

Configuration
REQ-030 Macro CSA_OVF_EN selects the signed-overflow feature.
REQ-031 With CSA_OVF_EN defined: port ovf_out exists and SHALL be 1 when the operand MSBs after subtract inversion are equal and differ from s_out MSB, pipelined and stalled with s_out.
REQ-032 Without CSA_OVF_EN: port ovf_out and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=16, SEG=4, out_ready=1 unless stated)
REQ-033 Hold rst_n=0 2 cycles with in_valid=1 -> out_valid=0, s_out=0x0000, cout_out=0, in_ready=1; no output after release.
REQ-034 Add 0xFFFF+0x0001, cin 0 at cycle t -> cycle t+2: s_out=0x0000, cout_out=1, ovf_out=0 (carry crosses all 4 segments).
REQ-035 Sub 0x0005-0x0007 -> s_out=0xFFFE, cout_out=0; sub 0x0007-0x0005 -> s_out=0x0002, cout_out=1.
REQ-036 CSA_OVF_EN: add 0x7FFF+0x0001 -> s_out=0x8000, ovf_out=1; sub 0x8000-0x0001 -> s_out=0x7FFF, ovf_out=1; build without macro compiles with no ovf_out port.
REQ-037 Inputs 1+1, 2+2, 3+3 back-to-back, out_ready low for cycles 2-4 -> in_ready low during stall, s_out held at 0x0002, then 0x0002, 0x0004, 0x0006 delivered in order once each.
REQ-038 Random 10k add/sub/cin with random out_ready vs reference model, plus rst_n pulse mid-stream -> zero mismatches, no result from pre-reset inputs.

Source files
------------

// File: rtl/carry_select_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with ready/valid handshake.
// Optional signed-overflow output is enabled by defining CSA_OVF_EN.
module carry_select_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             cout_out
`ifdef CSA_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int unsigned NSEG = (SEG == 0) ? 1 : WIDTH / SEG;
  localparam int unsigned NHI  = (NSEG > 1) ? NSEG - 1 : 1;

  generate
    if (WIDTH < 2 || SEG == 0 || (WIDTH % SEG) != 0) begin : g_bad_cfg
      $error("carry_select_pipe_adder: WIDTH must be >= 2 and a multiple of SEG");
    end
  endgenerate

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 inputs: subtract folds into operand inversion plus forced carry in
  logic [WIDTH-1:0]          b_eff;
  logic                      cin_eff;
  logic [NHI-1:0][SEG-1:0]   hi_s0_d, hi_s1_d;
  logic [NHI-1:0]            hi_c0_d, hi_c1_d;

  assign b_eff   = sub_in ? ~b_in : b_in;
  assign cin_eff = sub_in | cin_in;

  // Upper segments precompute both carry-in outcomes
  always_comb begin
    hi_s0_d = '0;
    hi_s1_d = '0;
    hi_c0_d = '0;
    hi_c1_d = '0;
    for (int k = 1; k < int'(NSEG); k++) begin
      {hi_c0_d[k-1], hi_s0_d[k-1]} = (SEG+1)'(a_in[k*SEG +: SEG]) + (SEG+1)'(b_eff[k*SEG +: SEG]);
      {hi_c1_d[k-1], hi_s1_d[k-1]} = (SEG+1)'(a_in[k*SEG +: SEG]) + (SEG+1)'(b_eff[k*SEG +: SEG])
                                     + (SEG+1)'(1);
    end
  end

  logic                      v1_q;
  logic [WIDTH-1:0]          a_q, b_q;
  logic                      cin_q;
  logic [NHI-1:0][SEG-1:0]   hi_s0_q, hi_s1_q;
  logic [NHI-1:0]            hi_c0_q, hi_c1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
    end
  end

  // Stage 1 payload carries no reset; it is qualified by v1_q
  always_ff @(posedge clk) begin
    if (adv) begin
      a_q     <= a_in;
      b_q     <= b_eff;
      cin_q   <= cin_eff;
      hi_s0_q <= hi_s0_d;
      hi_s1_q <= hi_s1_d;
      hi_c0_q <= hi_c0_d;
      hi_c1_q <= hi_c1_d;
    end
  end

  // Stage 2: segment 0 ripple, then carry chain selects precomputed segments
  logic [WIDTH-1:0] sum_sel;
  logic             sel_carry;

  always_comb begin
    sum_sel = '0;
    {sel_carry, sum_sel[SEG-1:0]} = (SEG+1)'(a_q[SEG-1:0]) + (SEG+1)'(b_q[SEG-1:0]) + (SEG+1)'(cin_q);
    for (int k = 1; k < int'(NSEG); k++) begin
      sum_sel[k*SEG +: SEG] = sel_carry ? hi_s1_q[k-1] : hi_s0_q[k-1];
      sel_carry             = sel_carry ? hi_c1_q[k-1] : hi_c0_q[k-1];
    end
  end

`ifdef CSA_OVF_EN
  logic ovf_sel;
  assign ovf_sel = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_sel[WIDTH-1] != a_q[WIDTH-1]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s_out     <= '0;
      cout_out  <= 1'b0;
`ifdef CSA_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= v1_q;
      s_out     <= sum_sel;
      cout_out  <= sel_carry;
`ifdef CSA_OVF_EN
      ovf_out   <= ovf_sel;
`endif
    end
  end

endmodule

// File: tb/tb_carry_select_pipe_adder.sv
// Bench for carry_select_pipe_adder: directed corner cases plus randomized
// traffic against an arithmetic reference queue; honours CSA_OVF_EN.
module tb_carry_select_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in, b_in;
  logic        cin_in, sub_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s_out;
  logic        cout_out;
`ifdef CSA_OVF_EN
  logic        ovf_out;
`endif

  carry_select_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
    .sub_in    (sub_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_out     (s_out),
    .cout_out  (cout_out)
`ifdef CSA_OVF_EN
    ,
    .ovf_out   (ovf_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_out = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t observed();
    res_t r;
    r.s = s_out;
    r.c = cout_out;
`ifdef CSA_OVF_EN
    r.o = ovf_out;
`else
    r.o = 1'b0;
`endif
    return r;
  endfunction

  // Reference: integer arithmetic on the operands as unsigned and signed values
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int   u;
    int   sr;
    if (sub) begin
      u  = int'(a) - int'(b) + 65536;
      sr = int'($signed(a)) - int'($signed(b));
    end else begin
      u  = int'(a) + int'(b) + int'(cin);
      sr = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    r.s = u[15:0];
    r.c = u[16];
`ifdef CSA_OVF_EN
    r.o = (sr > 32767) || (sr < -32768);
`else
    r.o = (sr > 100000);
`endif
    return r;
  endfunction

  // One clock cycle: drive, check pre-edge handshake/output, advance, update model
  task automatic cyc(input logic rst, input logic iv, input logic [15:0] a, input logic [15:0] b,
                     input logic cin, input logic sub, input logic ordy, output logic acc);
    logic pv;
    res_t ps;
    res_t ex;
    rst_n     = rst;
    in_valid  = iv;
    a_in      = a;
    b_in      = b;
    cin_in    = cin;
    sub_in    = sub;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
    pv  = out_valid;
    ps  = observed();
    acc = rst && iv && in_ready;
    if (rst && (pv === 1'b1) && ordy) begin
      check("pending_at_output", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check("result", 32'(ps), 32'(ex));
        n_out++;
      end
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_q.delete();
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_s_out", 32'(s_out), 32'(0));
      check("rst_cout", 32'(cout_out), 32'(0));
`ifdef CSA_OVF_EN
      check("rst_ovf", 32'(ovf_out), 32'(0));
`endif
    end else begin
      if (acc) exp_q.push_back(model(a, b, cin, sub));
      if ((pv === 1'b1) && !ordy) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_data", 32'(observed()), 32'(ps));
      end
      check("inflight_bound", 32'(exp_q.size() <= 2), 32'(1));
      check("valid_has_pending", 32'((out_valid === 1'b1) && (exp_q.size() == 0)), 32'(0));
    end
  endtask

  initial begin
    logic acc;
    int   n0;
    int   tries;

    // Reset held two cycles with inputs offered
    cyc(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, acc);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
      check("no_out_after_rst", 32'(out_valid), 32'(0));
    end

    // Full-width carry ripple through all segments, exact two-cycle latency
    cyc(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
    check("accept_first", 32'(acc), 32'(1));
    check("lat1_valid", 32'(out_valid), 32'(0));
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
    check("lat2_valid", 32'(out_valid), 32'(1));
    check("carry_all_s", 32'(s_out), 32'(16'h0000));
    check("carry_all_c", 32'(cout_out), 32'(1));
`ifdef CSA_OVF_EN
    check("carry_all_ovf", 32'(ovf_out), 32'(0));
`endif
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);

    // Subtraction with and without borrow; cin ignored in subtract mode
    cyc(1'b1, 1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, acc);
    cyc(1'b1, 1'b1, 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, acc);
    check("sub_borrow_s", 32'(s_out), 32'(16'hFFFE));
    check("sub_borrow_c", 32'(cout_out), 32'(0));
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
    check("sub_ok_s", 32'(s_out), 32'(16'h0002));
    check("sub_ok_c", 32'(cout_out), 32'(1));
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);

`ifdef CSA_OVF_EN
    cyc(1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, acc);
    check("ovf_add_s", 32'(s_out), 32'(16'h8000));
    check("ovf_add_o", 32'(ovf_out), 32'(1));
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
    check("ovf_sub_s", 32'(s_out), 32'(16'h7FFF));
    check("ovf_sub_o", 32'(ovf_out), 32'(1));
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
`endif

    // Back-to-back inputs with a downstream stall
    n0 = n_out;
    cyc(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b1, 1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, acc);
      check("stall_no_accept", 32'(acc), 32'(0));
      check("stall_in_ready", 32'(in_ready), 32'(0));
      check("stall_s_held", 32'(s_out), 32'(16'h0002));
    end
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 4) begin
      cyc(1'b1, 1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b1, acc);
      tries++;
    end
    check("stall_release_accept", 32'(acc), 32'(1));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
    check("stall_delivered", 32'(n_out - n0), 32'(3));
    check("stall_drained", 32'(exp_q.size()), 32'(0));

    // Random traffic with random backpressure and a reset pulse mid-stream
    for (int i = 0; i < 10000; i++) begin
      cyc(!(i >= 5000 && i < 5002),
          $urandom_range(0, 9) < 7,
          16'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom),
          $urandom_range(0, 3) != 0, acc);
    end
    tries = 0;
    while (exp_q.size() > 0 && tries < 8) begin
      cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
      tries++;
    end
    check("random_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
